control_sequencer: RTL

Registered, interrupt-aware successor to the combinational instruction decoder. It accepts 5-bit opcodes from fetch over a valid/ready handshake and emits one registered control word per accepted instruction (pc_mux, w_mux, mem_write, alu_op). It adds a wfi/rfi state machine and a parametrised interrupt controller. It sits between fetch and the datapath muxes/ALU.

---
 rtl/ctl_pkg.sv | 79 +++++++
 rtl/irq_arbiter.sv | 44 ++++
 rtl/control_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ctl_pkg.sv
// Shared encodings, FSM state type and control-word decode for control_sequencer.
package ctl_pkg;

  localparam logic [1:0] PC_ADD  = 2'd0;
  localparam logic [1:0] PC_WREG = 2'd1;
  localparam logic [1:0] PC_LIT  = 2'd2;
  localparam logic [1:0] PC_SAVE = 2'd3;

  localparam logic [1:0] W_ALU  = 2'd0;
  localparam logic [1:0] W_MEM  = 2'd1;
  localparam logic [1:0] W_LIT  = 2'd2;
  localparam logic [1:0] W_WREG = 2'd3;

  localparam logic [3:0] ALU_ROTL      = 4'h0;
  localparam logic [3:0] ALU_ROTR      = 4'h1;
  localparam logic [3:0] ALU_ADD       = 4'h2;
  localparam logic [3:0] ALU_SUB       = 4'h3;
  localparam logic [3:0] ALU_AND       = 4'h4;
  localparam logic [3:0] ALU_OR        = 4'h5;
  localparam logic [3:0] ALU_XOR       = 4'h6;
  localparam logic [3:0] ALU_ZEROT     = 4'h7;
  localparam logic [3:0] ALU_PCZERO    = 4'h8;
  localparam logic [3:0] ALU_PCZEROBAR = 4'h9;
  localparam logic [3:0] ALU_NOP       = 4'hA;

  // opcode[4:1] groups with sequencing side effects
  localparam logic [3:0] G_WFI = 4'hE;
  localparam logic [3:0] G_RFI = 4'hF;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ENTRY, ST_ISR} state_t;

  typedef struct packed {
    logic [1:0] pc_mux;
    logic [1:0] w_mux;
    logic       mem_write;
    logic [3:0] alu_op;
  } ctl_word_t;

  localparam ctl_word_t CTL_NOP = '{PC_ADD, W_WREG, 1'b0, ALU_NOP};

  // Opcode -> control word; anything not overridden keeps the NOP fields.
  function automatic ctl_word_t decode(input logic [4:0] op);
    logic [3:0] g;
    logic       b;
    ctl_word_t  w;
    g = op[4:1];
    b = op[0];
    w = CTL_NOP;
    case (g)
      4'h0: begin
        w.w_mux     = b ? W_WREG : W_MEM;
        w.mem_write = b;
        w.alu_op    = ALU_ZEROT;
      end
      4'h1: w.mem_write = 1'b1;
      4'h2: w.w_mux = W_LIT;
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
        w.w_mux     = b ? W_WREG : W_ALU;
        w.mem_write = b;
        case (g)
          4'h3:    w.alu_op = ALU_ROTL;
          4'h4:    w.alu_op = ALU_ROTR;
          4'h5:    w.alu_op = ALU_AND;
          4'h6:    w.alu_op = ALU_OR;
          4'h7:    w.alu_op = ALU_XOR;
          4'h8:    w.alu_op = ALU_ADD;
          default: w.alu_op = ALU_SUB;
        endcase
      end
      4'hA: w.alu_op = ALU_PCZERO;
      4'hB: w.alu_op = ALU_PCZEROBAR;
      4'hC: w.pc_mux = PC_LIT;
      4'hD: w.pc_mux = PC_WREG;
      default: w.pc_mux = PC_SAVE;  // wfi / rfi
    endcase
    return w;
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Picks one pending interrupt; fixed lowest-index or round-robin after last ack.
module irq_arbiter #(
  parameter int NUM_IRQ     = 4,
  parameter int RR_PRIORITY = 0,
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] pending,
  input  logic               ack,
  output logic [NUM_IRQ-1:0] grant,
  output logic [IW-1:0]      grant_id
);

  logic [IW-1:0] ptr;

  // scan from just past the pointer (round-robin) or from line 0 (fixed)
  always_comb begin
    int   base;
    int   j;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    base     = (RR_PRIORITY != 0) ? int'(ptr) + 1 : 0;
    j        = 0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      j = base + k;
      if (j >= NUM_IRQ) j = j - NUM_IRQ;
      if (!found && pending[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        grant_id = IW'(j);
      end
    end
  end

  // pointer only moves when an interrupt is actually acknowledged
  always_ff @(posedge clk) begin
    if (reset)                ptr <= IW'(NUM_IRQ - 1);
    else if (ack && |pending) ptr <= grant_id;
  end

endmodule

// File: rtl/control_sequencer.sv
// Registered decoder with wfi/rfi sequencing and interrupt entry.
module control_sequencer
  import ctl_pkg::*;
#(
  parameter int NUM_IRQ     = 4,
  parameter int RR_PRIORITY = 0,
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               mem_clock,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [4:0]         opcode,
  output logic               instr_ready,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_enable,
  output logic               ctl_valid,
  output logic [1:0]         pc_mux,
  output logic [1:0]         w_mux,
  output logic               mem_write,
  output logic [3:0]         alu_op,
  output logic               save_pc,
  output logic               restore_pc,
  output logic               vector_valid,
  output logic [IW-1:0]      vector_id,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_isr,
  output logic               illegal
);

  state_t             state, state_n;
  logic [NUM_IRQ-1:0] pending, pend_q, grant;
  logic [IW-1:0]      grant_id;
  ctl_word_t          word_q;
  logic               vld_q, restore_q, illegal_q;
  logic               any_pend, accept, is_wfi, is_rfi, taking;

  assign pending     = irq & irq_enable;
  assign any_pend    = |pending;
  // pending interrupt in RUN blocks fetch so the offered opcode is held, not dropped
  assign instr_ready = (state == ST_RUN && !any_pend) || state == ST_ISR;
  assign accept      = instr_valid && instr_ready;
  assign is_wfi      = opcode[4:1] == G_WFI;
  assign is_rfi      = opcode[4:1] == G_RFI;
  assign taking      = state == ST_ENTRY;
  assign in_isr      = state == ST_ISR;

  irq_arbiter #(.NUM_IRQ(NUM_IRQ), .RR_PRIORITY(RR_PRIORITY)) u_arb (
    .clk      (mem_clock),
    .reset    (reset),
    .pending  (pend_q),
    .ack      (taking),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // next-state: interrupts ignored inside the ISR (no nesting)
  always_comb begin
    state_n = state;
    case (state)
      ST_RUN: begin
        if (any_pend)              state_n = ST_ENTRY;
        else if (accept && is_wfi) state_n = ST_WAIT;
      end
      ST_WAIT:  if (any_pend) state_n = ST_ENTRY;
      ST_ENTRY: state_n = ST_ISR;
      ST_ISR:   if (accept && is_rfi) state_n = ST_RUN;
      default:  state_n = ST_RUN;
    endcase
  end

  // state register; snapshot the pending vector on the way into ENTRY
  always_ff @(posedge mem_clock) begin
    if (reset) begin
      state  <= ST_RUN;
      pend_q <= '0;
    end else begin
      state <= state_n;
      if (state_n == ST_ENTRY) pend_q <= pending;
    end
  end

  // one-cycle-latency control word for each accepted opcode
  always_ff @(posedge mem_clock) begin
    if (reset) begin
      vld_q     <= 1'b0;
      word_q    <= CTL_NOP;
      restore_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      vld_q     <= accept;
      word_q    <= accept ? decode(opcode) : CTL_NOP;
      restore_q <= accept && is_rfi && state == ST_ISR;
      illegal_q <= accept && is_rfi && state == ST_RUN;
    end
  end

  // output mux: ENTRY owns the bus (nothing was accepted the cycle before)
  always_comb begin
    ctl_valid                           = vld_q;
    {pc_mux, w_mux, mem_write, alu_op}  = word_q;
    save_pc                             = 1'b0;
    restore_pc                          = restore_q;
    illegal                             = illegal_q;
    vector_valid                        = 1'b0;
    vector_id                           = '0;
    irq_ack                             = '0;
    if (taking) begin
      ctl_valid    = 1'b1;
      pc_mux       = PC_SAVE;
      w_mux        = W_WREG;
      mem_write    = 1'b0;
      alu_op       = ALU_NOP;
      save_pc      = 1'b1;
      vector_valid = 1'b1;
      vector_id    = grant_id;
      irq_ack      = grant;
    end
  end

endmodule
